// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and iteration constants for muldiv_seq
package muldiv_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = 6;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      ITER = 2'd2,
      FIX  = 2'd3
   } state_t;

   // Counter value of the final step for a given operand width.
   function automatic int iter_last(input int width);
      return width - 1;
   endfunction

   localparam int ITER_LAST = iter_last(DEF_WIDTH);

endpackage

// File: rtl/muldiv_addsub.sv
// rtl/muldiv_addsub.sv - shared (WIDTH+1)-bit add/subtract step used by multiply and divide
module muldiv_addsub #(
   parameter int W = 33
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         sub,
   output logic [W-1:0] sum,
   output logic         carry
);

   logic [W-1:0] y_eff;

   // Subtraction is x + ~y + 1; carry out set means no borrow (x >= y).
   always_comb begin
      y_eff        = sub ? ~y : y;
      {carry, sum} = {1'b0, x} + {1'b0, y_eff} + {{W{1'b0}}, sub};
   end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - MULT/MULTU/DIV/DIVU sequencer owning HI/LO; optional MULDIV_EARLY_TERM_EN shortens multiplies
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             dz,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int LAST = (WIDTH == DEF_WIDTH) ? ITER_LAST : iter_last(WIDTH);

   state_t state, state_nx;

   logic [1:0]         op_r;
   logic [WIDTH-1:0]   a_r, b_r;
   logic [WIDTH-1:0]   acc;      // product high half / partial remainder
   logic [WIDTH-1:0]   mq;       // multiplier-then-product-low / dividend-then-quotient
   logic [WIDTH-1:0]   bop;      // multiplicand / divisor magnitude
   logic               neg_res, neg_rem, dz_r;
   logic [CNT_W-1:0]   cnt;

   logic               is_div, is_sgn, b_zero, last, early;
   logic [WIDTH-1:0]   a_abs, b_abs, quo_fix, rem_fix;
   logic [WIDTH:0]     as_x, as_y, as_sum, mul_new;
   logic               as_carry;
   logic [2*WIDTH-1:0] prod, prod_fix;
`ifdef MULDIV_EARLY_TERM_EN
   logic [CNT_W:0]     sh;
`endif

   muldiv_addsub #(.W(WIDTH + 1)) u_addsub (
      .x     (as_x),
      .y     (as_y),
      .sub   (is_div),
      .sum   (as_sum),
      .carry (as_carry)
   );

   // Operand decode, magnitudes, step-input muxing and sign fixup values.
   always_comb begin
      is_div   = (op_r == OP_DIV) || (op_r == OP_DIVU);
      is_sgn   = (op_r == OP_MULT) || (op_r == OP_DIV);
      b_zero   = (b_r == '0);
      last     = (cnt == CNT_W'(LAST));
      a_abs    = (is_sgn && a_r[WIDTH-1]) ? -a_r : a_r;
      b_abs    = (is_sgn && b_r[WIDTH-1]) ? -b_r : b_r;
      as_x     = is_div ? {acc, mq[WIDTH-1]} : {1'b0, acc};
      as_y     = {1'b0, bop};
      mul_new  = mq[0] ? as_sum : {1'b0, acc};
      prod     = {acc, mq};
      prod_fix = neg_res ? -prod : prod;
      quo_fix  = neg_res ? -mq : mq;
      rem_fix  = neg_rem ? -acc : acc;
`ifdef MULDIV_EARLY_TERM_EN
      sh       = (CNT_W + 1)'(WIDTH) - {1'b0, cnt};
      early    = !is_div && ((mq << cnt) == '0);
`else
      early    = 1'b0;
`endif
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = PREP;
         PREP:    state_nx = (is_div && b_zero) ? FIX : ITER;
         ITER:    if (last || early) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // Datapath: operand capture, iteration steps, result write-back and pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r <= '0; a_r <= '0; b_r <= '0;
         acc <= '0; mq <= '0; bop <= '0;
         neg_res <= 1'b0; neg_rem <= 1'b0; dz_r <= 1'b0;
         cnt <= '0; done <= 1'b0; dz <= 1'b0;
         hi <= '0; lo <= '0;
      end else begin
         done <= 1'b0;
         dz   <= 1'b0;
         case (state)
            IDLE: begin
               if (hi_we) hi <= wdata;
               if (lo_we) lo <= wdata;
               if (start) begin
                  op_r <= op;
                  a_r  <= a;
                  b_r  <= b;
               end
            end
            PREP: begin
               cnt     <= '0;
               acc     <= '0;
               neg_res <= is_sgn && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
               neg_rem <= is_sgn && is_div && a_r[WIDTH-1];
               dz_r    <= is_div && b_zero;
               if (is_div) begin
                  mq  <= a_abs;
                  bop <= b_abs;
               end else begin
                  mq  <= b_abs;
                  bop <= a_abs;
               end
            end
            ITER: begin
               cnt <= cnt + CNT_W'(1);
               if (is_div) begin
                  acc <= as_carry ? as_sum[WIDTH-1:0] : as_x[WIDTH-1:0];
                  mq  <= {mq[WIDTH-2:0], as_carry};
               end
`ifdef MULDIV_EARLY_TERM_EN
               else if (early) begin
                  {acc, mq} <= prod >> sh;
               end
`endif
               else begin
                  acc <= mul_new[WIDTH:1];
                  mq  <= {mul_new[0], mq[WIDTH-1:1]};
               end
            end
            FIX: begin
               done <= 1'b1;
               dz   <= dz_r;
               if (dz_r) begin
                  lo <= '1;
                  hi <= a_r;
               end else if (is_div) begin
                  lo <= quo_fix;
                  hi <= rem_fix;
               end else begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule
